// File: rtl/cgra_stimulus_engine.sv
// Stimulus/capture engine for CGRA bring-up: streams config beats, drives pad sides, captures one side.
// Optional MISR over captured data is enabled by defining STIM_SIGNATURE_EN (adds signature_out).
module cgra_stimulus_engine #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_SIDES      = 4,
  parameter int CFG_ADDR_WIDTH = 32,
  parameter int CFG_DATA_WIDTH = 32,
  parameter int CYCLE_WIDTH    = 32,
  localparam int SEL_WIDTH     = (NUM_SIDES > 1) ? $clog2(NUM_SIDES) : 1
) (
  input  logic                            clk_in,
  input  logic                            reset_in,
  input  logic                            start_in,
  input  logic [CYCLE_WIDTH-1:0]          max_cycles_in,
  input  logic                            cfg_valid_in,
  output logic                            cfg_ready_out,
  input  logic [CFG_ADDR_WIDTH-1:0]       cfg_addr_in,
  input  logic [CFG_DATA_WIDTH-1:0]       cfg_data_in,
  input  logic                            cfg_last_in,
  output logic [CFG_ADDR_WIDTH-1:0]       config_addr_out,
  output logic [CFG_DATA_WIDTH-1:0]       config_data_out,
  input  logic [2*NUM_SIDES-1:0]          side_mode_in,
  input  logic [DATA_WIDTH*NUM_SIDES-1:0] side_seed_in,
  output logic [DATA_WIDTH*NUM_SIDES-1:0] pad_data_out,
  input  logic [DATA_WIDTH*NUM_SIDES-1:0] pad_data_in,
  input  logic [SEL_WIDTH-1:0]            capture_sel_in,
  output logic                            capture_valid_out,
  output logic [DATA_WIDTH-1:0]           capture_data_out,
  output logic [CYCLE_WIDTH-1:0]          cycle_count_out,
`ifdef STIM_SIGNATURE_EN
  output logic [DATA_WIDTH-1:0]           signature_out,
`endif
  output logic                            busy_out,
  output logic                            done_out
);

  // state  | meaning
  // IDLE   | after reset, waiting for start
  // CONFIG | accepting config beats, forwarding them to the fabric
  // RUN    | stepping pad sides, capturing, counting cycles
  // DONE   | run budget spent, pads held until next start
  typedef enum logic [1:0] {IDLE, CONFIG, RUN, DONE} state_t;

  state_t state_q, state_d;
  logic cfg_accept, start_fire, run_entry, run_last;

  logic [CFG_ADDR_WIDTH-1:0]            cfg_addr_q;
  logic [CFG_DATA_WIDTH-1:0]            cfg_data_q;
  logic [NUM_SIDES-1:0][DATA_WIDTH-1:0] pad_q;
  logic [NUM_SIDES-1:0][1:0]            mode_q;
  logic [CYCLE_WIDTH-1:0]               count_q, remain_q;
  logic                                 cap_valid_q;
  logic [DATA_WIDTH-1:0]                cap_data_q, cap_sel_data;

  always_comb begin
    state_d    = state_q;
    cfg_accept = 1'b0;
    start_fire = 1'b0;
    run_entry  = 1'b0;
    run_last   = 1'b0;
    case (state_q)
      IDLE, DONE: if (start_in) begin
        start_fire = 1'b1;
        state_d    = CONFIG;
      end
      CONFIG: if (cfg_valid_in) begin
        cfg_accept = 1'b1;
        if (cfg_last_in) begin
          run_entry = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: if (remain_q == CYCLE_WIDTH'(1)) begin
        run_last = 1'b1;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    cap_sel_data = '0;
    for (int s = 0; s < NUM_SIDES; s++)
      if (capture_sel_in == SEL_WIDTH'(s)) cap_sel_data = pad_data_in[s*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      pad_q       <= '0;
      mode_q      <= '0;
      count_q     <= '0;
      remain_q    <= '0;
      cap_valid_q <= 1'b0;
      cap_data_q  <= '0;
    end else begin
      cfg_addr_q  <= cfg_accept ? cfg_addr_in : '0;
      cfg_data_q  <= cfg_accept ? cfg_data_in : '0;
      cap_valid_q <= (state_q == RUN);
      if (state_q == RUN) cap_data_q <= cap_sel_data;
      if (start_fire) begin
        count_q <= '0;
        pad_q   <= '0;
      end else if (run_entry) begin
        count_q  <= '0;
        remain_q <= (max_cycles_in == '0) ? CYCLE_WIDTH'(1) : max_cycles_in;
        for (int s = 0; s < NUM_SIDES; s++) begin
          mode_q[s] <= side_mode_in[2*s +: 2];
          pad_q[s]  <= (side_mode_in[2*s +: 2] == 2'd0) ? '0 : side_seed_in[s*DATA_WIDTH +: DATA_WIDTH];
        end
      end else if (state_q == RUN) begin
        count_q  <= count_q + CYCLE_WIDTH'(1);
        remain_q <= remain_q - CYCLE_WIDTH'(1);
        // Skip the step on the exit edge so DONE holds the last RUN value.
        if (!run_last) begin
          for (int s = 0; s < NUM_SIDES; s++) begin
            case (mode_q[s])
              2'd1:    pad_q[s] <= pad_q[s] + DATA_WIDTH'(1);
              2'd3:    pad_q[s] <= pad_q[s] - DATA_WIDTH'(1);
              default: pad_q[s] <= pad_q[s];
            endcase
          end
        end
      end
    end
  end

`ifdef STIM_SIGNATURE_EN
  localparam logic [DATA_WIDTH-1:0] TAP_MASK = (DATA_WIDTH == 16) ? DATA_WIDTH'(16'hB400)
                                             : (DATA_WIDTH'(3) << (DATA_WIDTH - 2));
  logic [DATA_WIDTH-1:0] sig_q;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in)        sig_q <= '0;
    else if (start_fire)  sig_q <= '0;
    else if (cap_valid_q) sig_q <= {sig_q[DATA_WIDTH-2:0], ^(sig_q & TAP_MASK)} ^ cap_data_q;
  end

  assign signature_out = sig_q;
`endif

  assign cfg_ready_out     = (state_q == CONFIG);
  assign config_addr_out   = cfg_addr_q;
  assign config_data_out   = cfg_data_q;
  assign pad_data_out      = pad_q;
  assign capture_valid_out = cap_valid_q;
  assign capture_data_out  = cap_data_q;
  assign cycle_count_out   = count_q;
  assign busy_out          = (state_q == CONFIG) || (state_q == RUN);
  assign done_out          = (state_q == DONE);

endmodule

// File: tb/tb_cgra_stimulus_engine.sv
// Scoreboard bench for cgra_stimulus_engine: config writes and captures are checked by a monitor
// against expectations pushed by the stimulus; pad sequences come from a closed-form model.
module tb_cgra_stimulus_engine;
  localparam int DW = 16, NS = 4, AW = 32, CDW = 32, CW = 32;

  logic              clk_in = 1'b0;
  logic              reset_in, start_in, cfg_valid_in, cfg_last_in;
  logic [CW-1:0]     max_cycles_in;
  logic              cfg_ready_out;
  logic [AW-1:0]     cfg_addr_in, config_addr_out;
  logic [CDW-1:0]    cfg_data_in, config_data_out;
  logic [2*NS-1:0]   side_mode_in;
  logic [DW*NS-1:0]  side_seed_in, pad_data_out, pad_data_in;
  logic [1:0]        capture_sel_in;
  logic              capture_valid_out, busy_out, done_out;
  logic [DW-1:0]     capture_data_out, cap_mask;
  logic [CW-1:0]     cycle_count_out;
`ifdef STIM_SIGNATURE_EN
  logic [DW-1:0]     signature_out;
`endif

  always #5 clk_in = ~clk_in;

  assign pad_data_in = pad_data_out ^ {NS{cap_mask}};

  cgra_stimulus_engine #(.DATA_WIDTH(DW), .NUM_SIDES(NS), .CFG_ADDR_WIDTH(AW),
                         .CFG_DATA_WIDTH(CDW), .CYCLE_WIDTH(CW)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in), .max_cycles_in(max_cycles_in),
    .cfg_valid_in(cfg_valid_in), .cfg_ready_out(cfg_ready_out), .cfg_addr_in(cfg_addr_in),
    .cfg_data_in(cfg_data_in), .cfg_last_in(cfg_last_in), .config_addr_out(config_addr_out),
    .config_data_out(config_data_out), .side_mode_in(side_mode_in), .side_seed_in(side_seed_in),
    .pad_data_out(pad_data_out), .pad_data_in(pad_data_in), .capture_sel_in(capture_sel_in),
    .capture_valid_out(capture_valid_out), .capture_data_out(capture_data_out),
    .cycle_count_out(cycle_count_out),
`ifdef STIM_SIGNATURE_EN
    .signature_out(signature_out),
`endif
    .busy_out(busy_out), .done_out(done_out));

  typedef struct { logic [AW-1:0] addr; logic [CDW-1:0] data; longint cyc; } cfg_t;
  cfg_t          cfg_q[$];
  logic [DW-1:0] cap_q[$];
  int            n_cmp = 0, n_err = 0;
  longint        cyc = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_pad(input logic [1:0] m, input logic [DW-1:0] seed, input int k);
    case (m)
      2'd1:    return seed + DW'(k);
      2'd3:    return seed - DW'(k);
      2'd2:    return seed;
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] misr(input logic [DW-1:0] s, input logic [DW-1:0] d);
    return {s[DW-2:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ d;
  endfunction

  // Monitor: every negedge, a config write is either the one due now or must be idle.
  always @(negedge clk_in) begin
    if (cfg_q.size() > 0 && cfg_q[0].cyc == cyc) begin
      cfg_t e;
      e = cfg_q.pop_front();
      check("cfg_addr", config_addr_out, e.addr);
      check("cfg_data", config_data_out, e.data);
    end else begin
      check("cfg_idle", {config_addr_out, config_data_out}, 64'd0);
    end
    if (capture_valid_out) begin
      if (cap_q.size() == 0) check("cap_extra", capture_valid_out, 1'b0);
      else                   check("cap_data", capture_data_out, cap_q.pop_front());
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready"}, cfg_ready_out, 0);
    check({tag, "_caddr"}, config_addr_out, 0);
    check({tag, "_pad"},   pad_data_out, 0);
    check({tag, "_capv"},  capture_valid_out, 0);
    check({tag, "_capd"},  capture_data_out, 0);
    check({tag, "_count"}, cycle_count_out, 0);
    check({tag, "_busy"},  busy_out, 0);
    check({tag, "_done"},  done_out, 0);
  endtask

  task automatic run_test(input logic [2*NS-1:0] modes, input logic [DW*NS-1:0] seeds,
                          input logic [CW-1:0] maxc, input logic [1:0] sel, input logic [DW-1:0] mask,
                          input int nbeats, input int gaps, input bit glitch, input bit directed,
                          input int reset_at);
    int n;
    logic [DW-1:0] sig;
    n = (maxc == 0) ? 1 : int'(maxc);
    @(negedge clk_in);
    side_mode_in = modes; side_seed_in = seeds; max_cycles_in = maxc;
    capture_sel_in = sel; cap_mask = mask;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    check("cfg_entry_ready", cfg_ready_out, 1);
    check("cfg_entry_busy",  busy_out, 1);
    check("cfg_entry_done",  done_out, 0);
    check("cfg_entry_count", cycle_count_out, 0);
    check("cfg_entry_pad",   pad_data_out, 0);
`ifdef STIM_SIGNATURE_EN
    check("cfg_entry_sig",   signature_out, 0);
`endif
    if (glitch) begin
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      check("cfg_glitch_ready", cfg_ready_out, 1);
    end
    sig = '0;
    for (int j = 0; j < n; j++) begin
      logic [DW-1:0] v;
      v = model_pad(modes[2*sel +: 2], seeds[DW*sel +: DW], j) ^ mask;
      cap_q.push_back(v);
      sig = misr(sig, v);
    end
    for (int b = 0; b < nbeats; b++) begin
      cfg_t e;
      repeat (gaps) begin
        cfg_valid_in = 1'b0;
        @(negedge clk_in);
      end
      e.addr = directed ? AW'(16 * (b + 1)) : AW'($urandom);
      e.data = directed ? CDW'(10 + b)     : CDW'($urandom);
      e.cyc  = cyc + 1;
      cfg_valid_in = 1'b1; cfg_addr_in = e.addr; cfg_data_in = e.data;
      cfg_last_in  = (b == nbeats - 1);
      cfg_q.push_back(e);
      @(negedge clk_in);
    end
    cfg_valid_in = 1'b0; cfg_last_in = 1'b0;
    check("run_ready_low", cfg_ready_out, 0);
    for (int k = 0; k < n; k++) begin
      for (int s = 0; s < NS; s++)
        check($sformatf("pad_s%0d_k%0d", s, k), pad_data_out[s*DW +: DW],
              model_pad(modes[2*s +: 2], seeds[DW*s +: DW], k));
      check("run_count", cycle_count_out, CW'(k));
      check("run_busy", busy_out, 1);
      if (k == 0) begin
        side_mode_in = 2*NS'($urandom); side_seed_in = {$urandom, $urandom};
        max_cycles_in = CW'($urandom_range(1, 3));
      end
      if (k == reset_at) begin
        @(posedge clk_in);
        #2 reset_in = 1'b0;
        #1 check_zero_outputs("rst_mid");
        cfg_q.delete(); cap_q.delete();
        @(negedge clk_in);
        reset_in = 1'b1;
        return;
      end
      start_in = glitch && (k == 1);
      @(negedge clk_in);
      start_in = 1'b0;
    end
    check("done_flag",  done_out, 1);
    check("done_busy",  busy_out, 0);
    check("done_count", cycle_count_out, CW'(n));
    check("done_trail", capture_valid_out, 1);
    @(negedge clk_in);
    check("done_hold_flag", done_out, 1);
    check("done_capv_low",  capture_valid_out, 0);
    for (int s = 0; s < NS; s++)
      check($sformatf("done_hold_s%0d", s), pad_data_out[s*DW +: DW],
            model_pad(modes[2*s +: 2], seeds[DW*s +: DW], n - 1));
`ifdef STIM_SIGNATURE_EN
    check("done_sig", signature_out, sig);
`endif
    check("cap_pending", cap_q.size(), 0);
    check("cfg_pending", cfg_q.size(), 0);
  endtask

  initial begin
    reset_in = 1'b0; start_in = 1'b0; cfg_valid_in = 1'b0; cfg_last_in = 1'b0;
    cfg_addr_in = '0; cfg_data_in = '0; max_cycles_in = '0; side_mode_in = '0;
    side_seed_in = '0; capture_sel_in = '0; cap_mask = '0;
    repeat (3) @(negedge clk_in);
    check_zero_outputs("reset");
    reset_in = 1'b1;

    // modes {1,3,2,0} on sides 0..3, three directed back-to-back beats, starts ignored
    run_test(8'b00_10_11_01, 64'hBEEF_1234_0001_FFFE, 32'd4, 2'd0, 16'h0000, 3, 0, 1'b1, 1'b1, -1);
    // loopback, max 0 -> exactly one capture of side 2
    run_test(8'b00_10_11_01, 64'hBEEF_1234_0001_FFFE, 32'd0, 2'd2, 16'h0000, 1, 0, 1'b0, 1'b1, -1);
    // beats separated by idle gaps
    run_test(8'b01_01_01_01, 64'h0000_7FFF_8000_FFFF, 32'd6, 2'd1, 16'h5A5A, 3, 2, 1'b0, 1'b1, -1);
    // reset at RUN cycle 7, then clean restart
    run_test(8'b00_00_00_01, 64'h0000_0000_0000_0005, 32'd20, 2'd0, 16'h0000, 1, 0, 1'b0, 1'b0, 7);
    check_zero_outputs("post_rst");
    run_test(8'b00_00_00_01, 64'h0000_0000_0000_0005, 32'd8, 2'd0, 16'h0000, 2, 1, 1'b0, 1'b0, -1);

    for (int i = 0; i < 12; i++)
      run_test(8'($urandom), {$urandom, $urandom}, CW'($urandom_range(0, 12)),
               2'($urandom_range(0, 3)), 16'($urandom), $urandom_range(1, 4),
               $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0, -1);

    repeat (2) @(negedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
